// File: rtl/gb_cpu_alu16_seq_if.sv
// Shared types for the 16-bit ALU sequencer and its request/response bus.
// The same bus carries the decode-side request and the 16-bit result back.
package gb_cpu_alu16_pkg;
    typedef enum logic [3:0] {
        ALU_NOP, ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR, ALU_OR, ALU_CP
    } alu_opcode_t;

    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } alu_flags_t;

    typedef struct packed {
        alu_opcode_t opcode;
        logic [7:0]  operand_a;
        logic [7:0]  operand_b;
    } alu_instruction_t;

    localparam logic [1:0] OP_ADD_HL = 2'd0;
    localparam logic [1:0] OP_ADD_SP = 2'd1;
    localparam logic [1:0] OP_INC16  = 2'd2;
    localparam logic [1:0] OP_DEC16  = 2'd3;
endpackage

interface gb_cpu_alu16_seq_if;
    import gb_cpu_alu16_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    alu_flags_t  flags_in;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    alu_flags_t  rsp_flags;

    modport master (
        output req_valid, req_op, req_a, req_b, flags_in, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, flags_in, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags
    );
endinterface

// File: rtl/gb_cpu_alu16_seq.sv
// Two-pass 16-bit arithmetic on the shared 8-bit ALU (low ADD, high ADC).
// Define GB_CPU_ALU16_FASTINC_EN to run INC16/DEC16 on a local incrementer.
//
// state | meaning
// IDLE  | ready for a request, ALU gets NOP
// LO    | ALU computes low byte with ADD, carry-in 0
// HI    | ALU computes high byte with ADC, carry-in from LO
// DONE  | response valid, held until rsp_ready
module gb_cpu_alu16_seq
    import gb_cpu_alu16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    gb_cpu_alu16_seq_if.slave bus,
    output alu_instruction_t  alu_instr_o,
    output alu_flags_t        alu_flags_o,
    input  logic [7:0]        alu_out_i,
    input  alu_flags_t        alu_flags_i
);
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q;
    logic [15:0] a_q, b_q;
    alu_flags_t  flags_q;
    logic [7:0]  lo_q, hi_q;
    logic        lo_h_q, lo_c_q, hi_h_q, hi_c_q;
    logic [15:0] fast_sum;
    logic        fast_op;
    logic        unused_flags;

    assign unused_flags = ^{alu_flags_i.z, alu_flags_i.n};

`ifdef GB_CPU_ALU16_FASTINC_EN
    localparam logic FAST_INC = 1'b1;
    assign fast_sum = (bus.req_op == OP_DEC16) ? bus.req_a - 16'd1 : bus.req_a + 16'd1;
`else
    localparam logic FAST_INC = 1'b0;
    assign fast_sum = 16'h0000;
`endif

    assign fast_op = FAST_INC && (bus.req_op == OP_INC16 || bus.req_op == OP_DEC16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 2'd0;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            flags_q <= '0;
            lo_q    <= 8'h00;
            hi_q    <= 8'h00;
            lo_h_q  <= 1'b0;
            lo_c_q  <= 1'b0;
            hi_h_q  <= 1'b0;
            hi_c_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (bus.req_valid) begin
                    op_q    <= bus.req_op;
                    a_q     <= bus.req_a;
                    b_q     <= bus.req_b;
                    flags_q <= bus.flags_in;
                    if (fast_op) {hi_q, lo_q} <= fast_sum;
                end
                S_LO: begin
                    lo_q   <= alu_out_i;
                    lo_h_q <= alu_flags_i.h;
                    lo_c_q <= alu_flags_i.c;
                end
                S_HI: begin
                    hi_q   <= alu_out_i;
                    hi_h_q <= alu_flags_i.h;
                    hi_c_q <= alu_flags_i.c;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        alu_instr_o = '{opcode: ALU_NOP, operand_a: 8'h00, operand_b: 8'h00};
        alu_flags_o = flags_q;
        case (state_q)
            S_IDLE: if (bus.req_valid) state_d = fast_op ? S_DONE : S_LO;
            S_LO: begin
                state_d               = S_HI;
                alu_instr_o.opcode    = ALU_ADD;
                alu_instr_o.operand_a = a_q[7:0];
                case (op_q)
                    OP_INC16: alu_instr_o.operand_b = 8'h01;
                    OP_DEC16: alu_instr_o.operand_b = 8'hFF;
                    default:  alu_instr_o.operand_b = b_q[7:0];
                endcase
                alu_flags_o.c = 1'b0;
            end
            S_HI: begin
                state_d               = S_DONE;
                alu_instr_o.opcode    = ALU_ADC;
                alu_instr_o.operand_a = a_q[15:8];
                case (op_q)
                    OP_ADD_HL: alu_instr_o.operand_b = b_q[15:8];
                    OP_ADD_SP: alu_instr_o.operand_b = {8{b_q[7]}};
                    OP_INC16:  alu_instr_o.operand_b = 8'h00;
                    default:   alu_instr_o.operand_b = 8'hFF;
                endcase
                alu_flags_o.c = lo_c_q;
            end
            S_DONE: if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ADD SP,e8 takes its flags from the low byte only; INC/DEC leave F untouched.
    always_comb begin
        case (op_q)
            OP_ADD_HL: bus.rsp_flags = '{z: flags_q.z, n: 1'b0, h: hi_h_q, c: hi_c_q};
            OP_ADD_SP: bus.rsp_flags = '{z: 1'b0, n: 1'b0, h: lo_h_q, c: lo_c_q};
            default:   bus.rsp_flags = flags_q;
        endcase
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.rsp_valid  = (state_q == S_DONE);
    assign bus.rsp_result = {hi_q, lo_q};
endmodule

// File: tb/tb_gb_cpu_alu16_seq.sv
// Scoreboard bench for gb_cpu_alu16_seq: directed cases, backpressure, reset, random ops.
// Includes a behavioural 8-bit ALU so the DUT sees real ADD/ADC results.
module tb_gb_cpu_alu16_seq;
    import gb_cpu_alu16_pkg::*;

`ifdef GB_CPU_ALU16_FASTINC_EN
    localparam int INC_LAT = 1;
`else
    localparam int INC_LAT = 3;
`endif

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        int          acc;
        int          lat;
        logic [7:0]  lo_a, lo_b, hi_a, hi_b;
        logic        lo_c;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    alu_instruction_t alu_instr;
    alu_flags_t       alu_flags_to_alu;
    logic [7:0]       alu_out;
    alu_flags_t       alu_flags_from_alu;

    gb_cpu_alu16_seq_if ifc();

    gb_cpu_alu16_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (ifc.slave),
        .alu_instr_o (alu_instr),
        .alu_flags_o (alu_flags_to_alu),
        .alu_out_i   (alu_out),
        .alu_flags_i (alu_flags_from_alu)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    int   ready_mode = 0;
    exp_t q[$];
    logic prev_valid = 1'b0, prev_ready = 1'b0;
    logic [15:0] held_res;
    logic [3:0]  held_flg;

    // 8-bit ALU model: Game Boy ADD/ADC flags
    always_comb begin
        logic [8:0] s;
        logic       cin;
        alu_out            = 8'h00;
        alu_flags_from_alu = '0;
        cin                = (alu_instr.opcode == ALU_ADC) ? alu_flags_to_alu.c : 1'b0;
        s                  = {1'b0, alu_instr.operand_a} + {1'b0, alu_instr.operand_b} + {8'd0, cin};
        if (alu_instr.opcode == ALU_ADD || alu_instr.opcode == ALU_ADC) begin
            alu_out              = s[7:0];
            alu_flags_from_alu.z = (s[7:0] == 8'h00);
            alu_flags_from_alu.n = 1'b0;
            alu_flags_from_alu.h = ({1'b0, alu_instr.operand_a[3:0]} + {1'b0, alu_instr.operand_b[3:0]} + {4'd0, cin}) > 5'd15;
            alu_flags_from_alu.c = s[8];
        end
    end

    function automatic exp_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] f, input int cyc);
        exp_t        e;
        int unsigned ua, ub, se;
        ua = a;
        ub = b;
        se = b[7] ? (ub & 32'hFF) + 32'hFF00 : (ub & 32'hFF);
        e.acc  = cyc;
        e.lat  = 3;
        e.lo_a = a[7:0];
        e.hi_a = a[15:8];
        case (op)
            OP_ADD_HL: begin
                e.res  = 16'((ua + ub) % 65536);
                e.flg  = {f[3], 1'b0, ((ua % 4096) + (ub % 4096)) > 4095, (ua + ub) > 65535};
                e.lo_b = b[7:0];
                e.hi_b = b[15:8];
            end
            OP_ADD_SP: begin
                e.res  = 16'((ua + se) % 65536);
                e.flg  = {1'b0, 1'b0, ((ua % 16) + (ub % 16)) > 15, ((ua % 256) + (ub % 256)) > 255};
                e.lo_b = b[7:0];
                e.hi_b = b[7] ? 8'hFF : 8'h00;
            end
            OP_INC16: begin
                e.res  = 16'((ua + 1) % 65536);
                e.flg  = f;
                e.lo_b = 8'h01;
                e.hi_b = 8'h00;
                e.lat  = INC_LAT;
            end
            default: begin
                e.res  = 16'((ua + 65535) % 65536);
                e.flg  = f;
                e.lo_b = 8'hFF;
                e.hi_b = 8'hFF;
                e.lat  = INC_LAT;
            end
        endcase
        e.lo_c = ((ua % 256) + e.lo_b) > 255;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) ifc.rsp_ready = 1'b1;
        else if (ready_mode == 1) ifc.rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor and request recorder, both sampled on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (q.size() > 0 && q[0].lat == 3) begin
                if (edge_cnt == q[0].acc + 1)
                    chk("alu_lo", {alu_instr.opcode, alu_instr.operand_a, alu_instr.operand_b, alu_flags_to_alu.c},
                        {ALU_ADD, q[0].lo_a, q[0].lo_b, 1'b0});
                if (edge_cnt == q[0].acc + 2)
                    chk("alu_hi", {alu_instr.opcode, alu_instr.operand_a, alu_instr.operand_b, alu_flags_to_alu.c},
                        {ALU_ADC, q[0].hi_a, q[0].hi_b, q[0].lo_c});
            end
            if (ifc.rsp_valid) begin
                chk("req_ready_busy", ifc.req_ready, 0);
                chk("alu_nop_done", alu_instr, {ALU_NOP, 16'h0000});
                if (!prev_valid) begin
                    if (q.size() == 0) chk("unexpected_rsp", 1, 0);
                    else chk("latency", edge_cnt - q[0].acc, q[0].lat);
                    held_res = ifc.rsp_result;
                    held_flg = ifc.rsp_flags;
                end else if (!prev_ready) begin
                    chk("hold_result", ifc.rsp_result, held_res);
                    chk("hold_flags", ifc.rsp_flags, held_flg);
                end
                if (ifc.rsp_ready && q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("result", ifc.rsp_result, e.res);
                    chk("flags", ifc.rsp_flags, e.flg);
                end
            end
            prev_valid = ifc.rsp_valid;
            prev_ready = ifc.rsp_ready;
            if (ifc.req_valid && ifc.req_ready)
                q.push_back(model(ifc.req_op, ifc.req_a, ifc.req_b, ifc.flags_in, edge_cnt));
        end
    end

    task automatic wait_accept(output int acc);
        int n = 0;
        acc = -1;
        forever begin
            @(negedge clk);
            if (ifc.req_ready) begin
                acc = edge_cnt;
                break;
            end
            n++;
            if (n > 40) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1 ifc.req_valid = 1'b0;
    endtask

    task automatic drive(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        ifc.req_valid = 1'b1;
        ifc.req_op    = op;
        ifc.req_a     = a;
        ifc.req_b     = b;
        ifc.flags_in  = f;
    endtask

    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        int acc;
        @(posedge clk);
        #1 drive(op, a, b, f);
        wait_accept(acc);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || ifc.rsp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int acc, h;
        ifc.req_valid = 1'b0;
        ifc.req_op    = 2'd0;
        ifc.req_a     = 16'h0000;
        ifc.req_b     = 16'h0000;
        ifc.flags_in  = '0;
        ifc.rsp_ready = 1'b1;
        #3;
        chk("rst_req_ready", ifc.req_ready, 1);
        chk("rst_rsp_valid", ifc.rsp_valid, 0);
        chk("rst_result", ifc.rsp_result, 16'h0000);
        chk("rst_flags", ifc.rsp_flags, 4'h0);
        chk("rst_alu_instr", alu_instr, {ALU_NOP, 16'h0000});
        chk("rst_alu_flags", alu_flags_to_alu, 4'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed cases
        send(OP_ADD_HL, 16'h0FFF, 16'h0001, 4'b1000);
        send(OP_ADD_HL, 16'hFFFF, 16'h0001, 4'b0000);
        send(OP_ADD_SP, 16'hFFF8, 16'h0008, 4'b1111);
        send(OP_ADD_SP, 16'h0005, 16'h00FE, 4'b0000);
        send(OP_INC16,  16'h00FF, 16'h1234, 4'b1011);
        send(OP_DEC16,  16'h0000, 16'h5678, 4'b1011);
        drain();

        // Backpressure: 4 cycles in DONE with a competing request
        ready_mode = 2;
        @(posedge clk);
        #2 ifc.rsp_ready = 1'b0;
        send(OP_ADD_HL, 16'h1234, 16'h4321, 4'b0000);
        h = 0;
        while (!ifc.rsp_valid && h < 20) begin
            @(negedge clk);
            h++;
        end
        @(posedge clk);
        #1 drive(OP_ADD_SP, 16'h8000, 16'h0081, 4'b1010);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 ifc.rsp_ready = 1'b1;
        @(negedge clk);
        h = edge_cnt;
        wait_accept(acc);
        chk("accept_after_release", acc, h + 1);
        ready_mode = 0;
        drain();

        // Reset during HI
        send(OP_ADD_HL, 16'hABCD, 16'h1111, 4'b0000);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", ifc.req_ready, 1);
        chk("mid_rst_rsp_valid", ifc.rsp_valid, 0);
        chk("mid_rst_result", ifc.rsp_result, 16'h0000);
        chk("mid_rst_flags", ifc.rsp_flags, 4'h0);
        chk("mid_rst_alu_instr", alu_instr, {ALU_NOP, 16'h0000});
        chk("mid_rst_alu_flags", alu_flags_to_alu, 4'h0);
        q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", ifc.req_ready, 1);
        send(OP_ADD_HL, 16'h0F00, 16'h0100, 4'b1000);
        drain();

        // Random traffic with random backpressure
        ready_mode = 1;
        for (int i = 0; i < 150; i++) begin
            logic [15:0] a;
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0: a = 16'hFFFF;
                1: a = 16'h0FFF;
                2: a = 16'h0000;
                default: ;
            endcase
            send(2'($urandom_range(0, 3)), a, 16'($urandom), 4'($urandom));
        end
        ready_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
